// File: rtl/titan_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : titan_pkg
//  Purpose  : Shared types and constants for the titan SPI register block:
//             frame geometry, address width, the status address and the
//             frame-decoder state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package titan_pkg;

    localparam int         FRAME_BITS  = 16;
    localparam int         ADDR_W      = 7;
    localparam logic [6:0] STATUS_ADDR = 7'h7F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } titan_state_e;

endpackage : titan_pkg
`default_nettype wire

// File: rtl/titan_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : titan_sync_edge
//  Purpose  : Brings one asynchronous pad signal into the sys_clock_i domain
//             through SYNC_STAGES flops, then adds one history flop so that
//             single-cycle rise and fall pulses can be produced.
//  Ports    : sys_clock_i    system clock
//             sys_reset_n_i  asynchronous active-low reset
//             async_i        asynchronous input pin
//             level_o        synchronised level
//             rise_o         one-cycle pulse on a synchronised 0->1 change
//             fall_o         one-cycle pulse on a synchronised 1->0 change
//  Revision : 1.0  initial release
// ============================================================================
module titan_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    // Idle level of the pin; chosen so that leaving reset creates no edge.
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic sys_clock_i,
    input  logic sys_reset_n_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge sys_clock_i or negedge sys_reset_n_i) begin
        if (!sys_reset_n_i) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  =  sync_q[SYNC_STAGES-1] & ~hist_q;
    assign fall_o  = ~sync_q[SYNC_STAGES-1] &  hist_q;

endmodule : titan_sync_edge
`default_nettype wire

// File: rtl/titan_spi_regs.sv
`default_nettype none
// ============================================================================
//  Module   : titan_spi_regs
//  Purpose  : SPI target (mode 0, MSB first) oversampled in the system clock
//             domain, decoding 16-bit frames {R/W, addr[6:0], data[7:0]} into
//             accesses to NUM_REGS 8-bit registers. Address 0x7F reads the
//             status_i input. Committed writes are announced with wr_stb_o.
//  Config   : TITAN_SPI_READBACK_EN - when defined, read frames return data on
//             spi_poci_o; when undefined spi_poci_o is tied low and read
//             frames have no effect.
//  Ports    : sys_clock_i, sys_reset_n_i    clock, async active-low reset
//             spi_clock_i/cs_i/pico_i       raw SPI pad inputs
//             spi_poci_o                    registered SPI data out
//             status_i                      read-only status byte
//             regs_o                        flat register file
//             wr_stb_o/wr_addr_o/wr_data_o  write-commit event
//             busy_o                        frame in progress
//  Revision : 1.0  initial release
// ============================================================================
module titan_spi_regs
    import titan_pkg::*;
#(
    parameter int NUM_REGS    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  sys_clock_i,
    input  logic                  sys_reset_n_i,
    input  logic                  spi_clock_i,
    input  logic                  spi_cs_i,
    input  logic                  spi_pico_i,
    output logic                  spi_poci_o,
    input  logic [7:0]            status_i,
    output logic [NUM_REGS*8-1:0] regs_o,
    output logic                  wr_stb_o,
    output logic [ADDR_W-1:0]     wr_addr_o,
    output logic [7:0]            wr_data_o,
    output logic                  busy_o
);

    localparam int                CNT_W      = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0]  CNT_HDR    = CNT_W'(FRAME_BITS/2 - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0]  CNT_DATA0  = CNT_W'(FRAME_BITS/2);
    localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

    // ------------------------------------------------------------------
    // Pin synchronisation
    // ------------------------------------------------------------------
    logic sck_level_unused, sck_rise, sck_fall;
    logic cs_level, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] pico_sync_q;
    logic pico;

    titan_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
        .sys_clock_i   (sys_clock_i),
        .sys_reset_n_i (sys_reset_n_i),
        .async_i       (spi_clock_i),
        .level_o       (sck_level_unused),
        .rise_o        (sck_rise),
        .fall_o        (sck_fall)
    );

    titan_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .sys_clock_i   (sys_clock_i),
        .sys_reset_n_i (sys_reset_n_i),
        .async_i       (spi_cs_i),
        .level_o       (cs_level),
        .rise_o        (cs_rise),
        .fall_o        (cs_fall)
    );

    // PICO only needs its level; it travels the same depth as SCK so the
    // bit is aligned with the detected rising edge.
    always_ff @(posedge sys_clock_i or negedge sys_reset_n_i) begin
        if (!sys_reset_n_i) begin
            pico_sync_q <= '0;
        end else begin
            pico_sync_q <= {pico_sync_q[SYNC_STAGES-2:0], spi_pico_i};
        end
    end
    assign pico = pico_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Frame decoder state
    // ------------------------------------------------------------------
    titan_state_e          state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [7:0]            shift_q, shift_d;
    logic                  rw_q, rw_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [NUM_REGS*8-1:0] regs_q;
    logic                  wr_stb_q;
    logic [ADDR_W-1:0]     wr_addr_q;
    logic [7:0]            wr_data_q;
    logic                  busy_q;
    logic                  commit;
    logic [7:0]            commit_data;
    logic                  addr_valid;

    // Status address sits above every legal register, but it is excluded
    // explicitly so the rule survives a change to the address range.
    assign addr_valid  = ({1'b0, addr_q} < NUM_REGS_W) && (addr_q != STATUS_ADDR);
    // The 16th bit is still on the PICO sync output when the edge is seen.
    assign commit_data = {shift_q[6:0], pico};

`ifdef TITAN_SPI_READBACK_EN
    logic [7:0]        out_q, out_d;
    logic              poci_q, poci_d;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;

    // Address as it will be latched on the 8th rising edge.
    assign rd_addr = {shift_q[5:0], pico};

    always_comb begin
        rd_data = 8'h00;
        if (rd_addr == STATUS_ADDR) begin
            rd_data = status_i;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (rd_addr == ADDR_W'(i)) begin
                    rd_data = regs_q[i*8 +: 8];
                end
            end
        end
    end
`else
    logic status_unused;
    assign status_unused = ^status_i;
`endif

    always_ff @(posedge sys_clock_i or negedge sys_reset_n_i) begin
        if (!sys_reset_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
`ifdef TITAN_SPI_READBACK_EN
            out_q   <= '0;
            poci_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
`ifdef TITAN_SPI_READBACK_EN
            out_q   <= out_d;
            poci_q  <= poci_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        commit  = 1'b0;
`ifdef TITAN_SPI_READBACK_EN
        out_d   = out_q;
        poci_d  = poci_q;
`endif
        if (cs_rise) begin
            // Deselect ends any frame; an unfinished one is abandoned.
            state_d = IDLE;
            cnt_d   = '0;
`ifdef TITAN_SPI_READBACK_EN
            poci_d  = 1'b0;
`endif
        end else if (cs_fall) begin
            // Also covers a CS glitch: restart the frame from scratch.
            state_d = ADDR;
            cnt_d   = '0;
`ifdef TITAN_SPI_READBACK_EN
            poci_d  = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d   = '0;
                    shift_d = '0;
`ifdef TITAN_SPI_READBACK_EN
                    poci_d  = 1'b0;
`endif
                end
                ADDR: begin
                    if (sck_rise) begin
                        shift_d = {shift_q[6:0], pico};
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_HDR) begin
                            rw_d    = shift_q[6];
                            addr_d  = {shift_q[5:0], pico};
                            state_d = DATA;
`ifdef TITAN_SPI_READBACK_EN
                            if (shift_q[6]) begin
                                out_d  = rd_data;
                                poci_d = rd_data[7];
                            end
`endif
                        end
                    end
                end
                DATA: begin
                    if (sck_rise) begin
                        shift_d = {shift_q[6:0], pico};
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_LAST) begin
                            state_d = DONE;
                            commit  = !rw_q && addr_valid;
`ifdef TITAN_SPI_READBACK_EN
                            poci_d  = 1'b0;
`endif
                        end
                    end
`ifdef TITAN_SPI_READBACK_EN
                    // The falling edge right after the 8th rise must keep
                    // the MSB on the line: it is sampled on the 9th rise.
                    else if (sck_fall && rw_q && (cnt_q != CNT_DATA0)) begin
                        out_d  = {out_q[6:0], 1'b0};
                        poci_d = out_q[6];
                    end
`endif
                end
                DONE: begin
`ifdef TITAN_SPI_READBACK_EN
                    poci_d = 1'b0;
`endif
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register file and write-event outputs
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clock_i or negedge sys_reset_n_i) begin
        if (!sys_reset_n_i) begin
            regs_q    <= '0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            wr_stb_q <= commit;
            busy_q   <= ~cs_level;
            if (commit) begin
                wr_addr_q <= addr_q;
                wr_data_q <= commit_data;
            end
            for (int i = 0; i < NUM_REGS; i++) begin
                if (commit && (addr_q == ADDR_W'(i))) begin
                    regs_q[i*8 +: 8] <= commit_data;
                end
            end
        end
    end

    assign regs_o    = regs_q;
    assign wr_stb_o  = wr_stb_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    assign busy_o    = busy_q;
`ifdef TITAN_SPI_READBACK_EN
    assign spi_poci_o = poci_q;
`else
    assign spi_poci_o = 1'b0;
`endif

endmodule : titan_spi_regs
`default_nettype wire
